// File: rtl/pingpong_operand_buffer.sv
// Two-bank ping-pong operand buffer feeding the 32-bit 2:1 mux chain.
// Producer fills one bank while the consumer reads the other through Select.
module pingpong_operand_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] bank0,
    output logic [WIDTH-1:0] bank1,
    output logic             Select,
    output logic [1:0]       occupancy
);

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wp;
    logic       rp;
    logic       wr_fire;
    logic       rd_fire;

    // Handshake outputs come only from registered state.
    assign wr_ready  = ~full[wp];
    assign rd_valid  = full[rp];
    assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};
    assign Select    = rp;

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    // A write targets an empty bank and a read a full one, so they never collide.
    always_comb begin
        full_nxt = full;
        if (wr_fire) full_nxt[wp] = 1'b1;
        if (rd_fire) full_nxt[rp] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank0 <= '0;
            bank1 <= '0;
            full  <= 2'b00;
            wp    <= 1'b0;
            rp    <= 1'b0;
        end else if (flush) begin
            full <= 2'b00;
            wp   <= 1'b0;
            rp   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wp) bank1 <= wr_data;
                else    bank0 <= wr_data;
                wp <= ~wp;
            end
            if (rd_fire) rp <= ~rp;
        end
    end

endmodule
